// File: rtl/cache_writeback_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_writeback_buffer_if
// Description : Signal bundle between the D$ eviction/fetch path, the
//               writeback buffer and the AHB cache interface.
//               slave  - buffer side (accepts evictions, drives bursts)
//               master - cache/bus side (drives evictions, probes, accepts)
// Ports       : EnqValid/EnqReady/EnqAdr/EnqLine  - eviction deposit
//               LookupAdr/LookupHit/LookupLine     - refetch forwarding probe
//               BusHold/BusValid/BusReady/BusAdr/BusBeat/BusData/BusLast
//                                                  - burst drain
//               Count/Empty                        - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_writeback_buffer_if #(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int BUSW    = 64,
  parameter int DEPTH   = 4
);
  localparam int BEATS = LINELEN / BUSW;
  localparam int LOGB  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic               EnqValid;
  logic               EnqReady;
  logic [PA_BITS-1:0] EnqAdr;
  logic [LINELEN-1:0] EnqLine;
  logic [PA_BITS-1:0] LookupAdr;
  logic               LookupHit;
  logic [LINELEN-1:0] LookupLine;
  logic               BusHold;
  logic               BusValid;
  logic               BusReady;
  logic [PA_BITS-1:0] BusAdr;
  logic [LOGB-1:0]    BusBeat;
  logic [BUSW-1:0]    BusData;
  logic               BusLast;
  logic [CNTW-1:0]    Count;
  logic               Empty;

  modport slave (
    input  EnqValid, EnqAdr, EnqLine, LookupAdr, BusHold, BusReady,
    output EnqReady, LookupHit, LookupLine, BusValid, BusAdr, BusBeat,
           BusData, BusLast, Count, Empty
  );

  modport master (
    output EnqValid, EnqAdr, EnqLine, LookupAdr, BusHold, BusReady,
    input  EnqReady, LookupHit, LookupLine, BusValid, BusAdr, BusBeat,
           BusData, BusLast, Count, Empty
  );
endinterface
`default_nettype wire

// File: rtl/cache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cache_writeback_buffer
// Description : DEPTH-entry FIFO of evicted dirty lines. Evictions are
//               accepted in one cycle, drained to the bus head-first as
//               BEATS-beat bursts, and forwarded to refetch probes while
//               still buffered (youngest matching copy wins).
// Ports       : clk     - rising-edge clock
//               reset_n - asynchronous active-low reset
//               wb      - cache_writeback_buffer_if.slave bundle
// Revision    : 1.0 - initial release
// ============================================================================
module cache_writeback_buffer #(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int BUSW    = 64,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cache_writeback_buffer_if.slave  wb
);
  localparam int BEATS = LINELEN / BUSW;
  localparam int LOGB  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int OFFB  = $clog2(LINELEN / 8);
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [DEPTH-1:0]   r_valid;
  logic [PA_BITS-1:0] r_adr  [DEPTH];
  logic [LINELEN-1:0] r_line [DEPTH];
  logic [PTRW-1:0]    r_head;
  logic [PTRW-1:0]    r_tail;
  logic [CNTW-1:0]    r_count;
  logic [LOGB-1:0]    r_beat;

  logic               w_enqFire;
  logic               w_startBurst;
  logic               w_beatAdv;
  logic               w_pop;
  logic               w_lastBeat;
  logic               w_hit;
  logic [PTRW-1:0]    w_hitIdx;
  logic [PTRW-1:0]    w_idx;
  logic [LINELEN-1:0] w_headLine;
  logic [BUSW-1:0]    w_beatWords [BEATS];
  logic               w_unused;

  // Byte-offset bits of the addresses never participate.
  assign w_unused = ^{wb.EnqAdr[OFFB-1:0], wb.LookupAdr[OFFB-1:0]};

  // Acceptance is based on registered occupancy only, so a pop in the same
  // cycle never frees a slot for the same-cycle enqueue.
  assign wb.EnqReady = (r_count < CNTW'(DEPTH));
  assign w_enqFire   = wb.EnqValid & wb.EnqReady;
  assign w_lastBeat  = (r_beat == LOGB'(BEATS - 1));

  // --------------------------------------------------------------------------
  // Drain FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_startBurst = 1'b0;
    w_beatAdv    = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_count != '0) && !wb.BusHold) begin
          w_nextState  = SEND;
          w_startBurst = 1'b1;
        end
      end
      SEND: begin
        // BusHold only gates burst starts; an active burst always finishes.
        if (wb.BusReady) begin
          w_beatAdv = 1'b1;
          if (w_lastBeat) begin
            w_pop       = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat <= '0;
    end else if (w_startBurst || w_pop) begin
      r_beat <= '0;
    end else if (w_beatAdv) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers: power-of-two DEPTH lets them wrap naturally.
  // --------------------------------------------------------------------------
  if (DEPTH > 1) begin : g_ptrs
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_pop)     r_head <= r_head + 1'b1;
        if (w_enqFire) r_tail <= r_tail + 1'b1;
      end
    end
  end else begin : g_ptrsSingle
    assign r_head = '0;
    assign r_tail = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_enqFire, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. Head and tail can only coincide when the buffer is empty
  // (no pop) or full (no enqueue), so the two writes never collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_adr[i]  <= '0;
        r_line[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
      end
      if (w_enqFire) begin
        r_valid[r_tail] <= 1'b1;
        r_adr[r_tail]   <= {wb.EnqAdr[PA_BITS-1:OFFB], {OFFB{1'b0}}};
        r_line[r_tail]  <= wb.EnqLine;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding lookup: scan oldest to youngest so the last match (youngest)
  // is the one kept.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = PTRW'((int'(r_head) + i) % DEPTH);
      if (r_valid[w_idx] &&
          (r_adr[w_idx][PA_BITS-1:OFFB] == wb.LookupAdr[PA_BITS-1:OFFB])) begin
        w_hit    = 1'b1;
        w_hitIdx = w_idx;
      end
    end
  end

  assign wb.LookupHit  = w_hit;
  assign wb.LookupLine = w_hit ? r_line[w_hitIdx] : '0;

  // --------------------------------------------------------------------------
  // Bus side: head entry split into beat words.
  // --------------------------------------------------------------------------
  assign w_headLine = r_line[r_head];

  for (genvar b = 0; b < BEATS; b++) begin : g_beats
    assign w_beatWords[b] = w_headLine[b*BUSW +: BUSW];
  end

  assign wb.BusValid = (r_state == SEND);
  assign wb.BusAdr   = r_adr[r_head];
  assign wb.BusBeat  = r_beat;
  assign wb.BusData  = w_beatWords[r_beat];
  assign wb.BusLast  = wb.BusValid & w_lastBeat;
  assign wb.Count    = r_count;
  assign wb.Empty    = (r_count == '0) && (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_writeback_buffer
// Description : Directed self-checking bench for cache_writeback_buffer with
//               PA_BITS=56, LINELEN=512, BUSW=64, DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_writeback_buffer;
  localparam int PA_BITS = 56;
  localparam int LINELEN = 512;
  localparam int BUSW    = 64;
  localparam int DEPTH   = 4;

  logic clk;
  logic reset_n;
  int   nChecks;
  int   nPass;

  cache_writeback_buffer_if #(
    .PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSW(BUSW), .DEPTH(DEPTH)
  ) ifc ();

  cache_writeback_buffer #(
    .PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSW(BUSW), .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LINELEN-1:0] mkLine(input logic [63:0] base);
    logic [LINELEN-1:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n       = 1'b0;
    ifc.EnqValid  = 1'b0;
    ifc.EnqAdr    = '0;
    ifc.EnqLine   = '0;
    ifc.LookupAdr = '0;
    ifc.BusHold   = 1'b0;
    ifc.BusReady  = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic enq(input logic [PA_BITS-1:0] a, input logic [LINELEN-1:0] l);
    ifc.EnqValid = 1'b1;
    ifc.EnqAdr   = a;
    ifc.EnqLine  = l;
    tick();
    ifc.EnqValid = 1'b0;
  endtask

  // Waits (bounded) for a burst and records its beats; reports stall
  // instability and address changes inside the burst via stabErr.
  task automatic collectBurst(input bit toggle,
                              output logic [PA_BITS-1:0] adr,
                              output logic [LINELEN-1:0] line,
                              output int nBeats, output int waitCyc,
                              output int stabErr, output bit done);
    logic [PA_BITS-1:0] pAdr;
    logic [2:0]         pBeat;
    logic [63:0]        pData;
    bit                 stalled;
    bit                 rdy;
    done = 0; nBeats = 0; waitCyc = 0; stabErr = 0;
    line = '0; adr = '0; stalled = 0;
    pAdr = '0; pBeat = '0; pData = '0;
    while (ifc.BusValid !== 1'b1 && waitCyc < 64) begin
      tick();
      waitCyc++;
    end
    if (ifc.BusValid !== 1'b1) return;
    adr = ifc.BusAdr;
    for (int c = 0; c < 64 && !done; c++) begin
      rdy = toggle ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      ifc.BusReady = rdy;
      if (stalled && (ifc.BusAdr !== pAdr || ifc.BusBeat !== pBeat ||
                      ifc.BusData !== pData)) stabErr++;
      if (ifc.BusAdr !== adr) stabErr++;
      if (ifc.BusValid === 1'b1 && rdy) begin
        line[ifc.BusBeat*64 +: 64] = ifc.BusData;
        nBeats++;
        if (ifc.BusLast === 1'b1) done = 1;
      end
      stalled = (ifc.BusValid === 1'b1) && !rdy;
      pAdr  = ifc.BusAdr;
      pBeat = ifc.BusBeat;
      pData = ifc.BusData;
      tick();
    end
    ifc.BusReady = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    doReset();
    nChecks++; if (ifc.BusValid !== 1'b0) $display("FAIL reset_busvalid got=%b exp=0", ifc.BusValid); else nPass++;
    nChecks++; if (ifc.BusLast !== 1'b0) $display("FAIL reset_buslast got=%b exp=0", ifc.BusLast); else nPass++;
    nChecks++; if (ifc.LookupHit !== 1'b0) $display("FAIL reset_hit got=%b exp=0", ifc.LookupHit); else nPass++;
    nChecks++; if (ifc.LookupLine !== '0) $display("FAIL reset_line got=%h exp=0", ifc.LookupLine); else nPass++;
    nChecks++; if (ifc.Count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", ifc.Count); else nPass++;
    nChecks++; if (ifc.Empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", ifc.Empty); else nPass++;
    nChecks++; if (ifc.EnqReady !== 1'b1) $display("FAIL reset_enqready got=%b exp=1", ifc.EnqReady); else nPass++;
    nChecks++; if (ifc.BusAdr !== '0 || ifc.BusData !== '0) $display("FAIL reset_busadr_data got=%h/%h exp=0/0", ifc.BusAdr, ifc.BusData); else nPass++;
  endtask

  task automatic test_single();
    logic [PA_BITS-1:0] a;
    a = 56'h8000_1040;
    enq(a, mkLine(64'd0));
    nChecks++; if (ifc.Count !== 3'd1 || ifc.Empty !== 1'b0) $display("FAIL single_enq count=%0d empty=%b exp=1/0", ifc.Count, ifc.Empty); else nPass++;
    nChecks++; if (ifc.BusValid !== 1'b0) $display("FAIL single_idle_gap busvalid=%b exp=0", ifc.BusValid); else nPass++;
    tick();
    for (int k = 0; k < 8; k++) begin
      nChecks++;
      if (ifc.BusValid !== 1'b1 || ifc.BusAdr !== a || ifc.BusBeat !== 3'(k) ||
          ifc.BusData !== 64'(k) || ifc.BusLast !== (k == 7))
        $display("FAIL single_beat%0d valid=%b adr=%h beat=%0d data=%h last=%b exp=1/%h/%0d/%0h/%b",
                 k, ifc.BusValid, ifc.BusAdr, ifc.BusBeat, ifc.BusData, ifc.BusLast, a, k, k, (k == 7));
      else nPass++;
      tick();
    end
    nChecks++; if (ifc.Count !== 3'd0 || ifc.Empty !== 1'b1 || ifc.BusValid !== 1'b0) $display("FAIL single_done count=%0d empty=%b valid=%b exp=0/1/0", ifc.Count, ifc.Empty, ifc.BusValid); else nPass++;
  endtask

  task automatic test_fill();
    logic [PA_BITS-1:0] adrs [4];
    logic [PA_BITS-1:0] gotAdr;
    logic [LINELEN-1:0] gotLine;
    int nb, wc, se;
    bit ok;
    adrs[0] = 56'h1000; adrs[1] = 56'h2000; adrs[2] = 56'h3000; adrs[3] = 56'h4000;
    doReset();
    ifc.BusHold = 1'b1;
    for (int i = 0; i < 4; i++) enq(adrs[i], mkLine(64'h100 * 64'(i + 1)));
    nChecks++; if (ifc.Count !== 3'd4 || ifc.EnqReady !== 1'b0) $display("FAIL fill_full count=%0d ready=%b exp=4/0", ifc.Count, ifc.EnqReady); else nPass++;
    enq(56'h5000, mkLine(64'h500));
    nChecks++; if (ifc.Count !== 3'd4 || ifc.BusValid !== 1'b0) $display("FAIL fill_fifth count=%0d valid=%b exp=4/0", ifc.Count, ifc.BusValid); else nPass++;
    ifc.BusHold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
      nChecks++;
      if (!ok || gotAdr !== adrs[i] || gotLine !== mkLine(64'h100 * 64'(i + 1)) || nb != 8 || wc != 1)
        $display("FAIL fill_burst%0d done=%b adr=%h beats=%0d gap=%0d exp=1/%h/8/1", i, ok, gotAdr, nb, wc, adrs[i]);
      else nPass++;
      nChecks++;
      if (ifc.BusValid !== 1'b0 || ifc.EnqReady !== 1'b1 || ifc.Count !== 3'(3 - i))
        $display("FAIL fill_after%0d valid=%b ready=%b count=%0d exp=0/1/%0d", i, ifc.BusValid, ifc.EnqReady, ifc.Count, 3 - i);
      else nPass++;
    end
    nChecks++; if (ifc.Empty !== 1'b1) $display("FAIL fill_empty got=%b exp=1", ifc.Empty); else nPass++;
  endtask

  task automatic test_forward();
    logic [PA_BITS-1:0] x;
    logic [PA_BITS-1:0] gotAdr;
    logic [LINELEN-1:0] gotLine;
    int nb, wc, se;
    bit ok;
    x = 56'h8000_2000;
    doReset();
    ifc.BusHold = 1'b1;
    enq(x, mkLine(64'hA00));
    enq(x, mkLine(64'hB00));
    ifc.LookupAdr = x + 56'h18;
    #1;
    nChecks++; if (ifc.LookupHit !== 1'b1 || ifc.LookupLine !== mkLine(64'hB00)) $display("FAIL fwd_youngest hit=%b line0=%h exp=1/b00", ifc.LookupHit, ifc.LookupLine[63:0]); else nPass++;
    ifc.LookupAdr = 56'h9000_0000;
    #1;
    nChecks++; if (ifc.LookupHit !== 1'b0 || ifc.LookupLine !== '0) $display("FAIL fwd_miss hit=%b line0=%h exp=0/0", ifc.LookupHit, ifc.LookupLine[63:0]); else nPass++;
    ifc.LookupAdr = x + 56'h18;
    ifc.BusHold = 1'b0;
    collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || gotLine !== mkLine(64'hA00)) $display("FAIL fwd_order1 done=%b line0=%h exp=1/a00", ok, gotLine[63:0]); else nPass++;
    collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || gotLine !== mkLine(64'hB00)) $display("FAIL fwd_order2 done=%b line0=%h exp=1/b00", ok, gotLine[63:0]); else nPass++;
    nChecks++; if (ifc.LookupHit !== 1'b0 || ifc.LookupLine !== '0) $display("FAIL fwd_drained hit=%b line0=%h exp=0/0", ifc.LookupHit, ifc.LookupLine[63:0]); else nPass++;
  endtask

  task automatic test_backpressure();
    logic [PA_BITS-1:0] gotAdr;
    logic [LINELEN-1:0] gotLine;
    int nb, wc, se;
    bit ok;
    doReset();
    enq(56'h0000_3080, mkLine(64'hC00));
    collectBurst(1'b1, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || nb != 8) $display("FAIL bp_beats done=%b got=%0d exp=8", ok, nb); else nPass++;
    nChecks++; if (se != 0) $display("FAIL bp_stable unstable=%0d exp=0", se); else nPass++;
    nChecks++; if (gotAdr !== 56'h0000_3080 || gotLine !== mkLine(64'hC00)) $display("FAIL bp_data adr=%h line0=%h exp=3080/c00", gotAdr, gotLine[63:0]); else nPass++;
    nChecks++; if (ifc.Empty !== 1'b1) $display("FAIL bp_empty got=%b exp=1", ifc.Empty); else nPass++;
  endtask

  task automatic test_back_to_back();
    logic [PA_BITS-1:0] gotAdr;
    logic [LINELEN-1:0] gotLine;
    int nb, wc, se, n;
    bit ok;
    // Full buffer: the last-beat enqueue is refused.
    doReset();
    ifc.BusHold = 1'b1;
    for (int i = 0; i < 4; i++) enq(56'h1_0000 * 56'(i + 1), mkLine(64'h1000 * 64'(i + 1)));
    ifc.BusHold = 1'b0;
    n = 0;
    while (!(ifc.BusValid === 1'b1 && ifc.BusLast === 1'b1) && n < 64) begin tick(); n++; end
    nChecks++; if (n >= 64) $display("FAIL b2b_full_wait got=timeout exp=last beat"); else nPass++;
    ifc.EnqValid = 1'b1; ifc.EnqAdr = 56'hF_0000; ifc.EnqLine = mkLine(64'hF000);
    #1;
    nChecks++; if (ifc.EnqReady !== 1'b0) $display("FAIL b2b_full_ready got=%b exp=0", ifc.EnqReady); else nPass++;
    tick();
    ifc.EnqValid = 1'b0;
    nChecks++; if (ifc.Count !== 3'd3) $display("FAIL b2b_full_count got=%0d exp=3", ifc.Count); else nPass++;
    for (int i = 0; i < 3; i++) collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || gotAdr !== 56'h4_0000 || ifc.Count !== 3'd0) $display("FAIL b2b_full_drain adr=%h count=%0d exp=40000/0", gotAdr, ifc.Count); else nPass++;
    // Count=2: enqueue and pop together keep Count and append at the tail.
    doReset();
    ifc.BusHold = 1'b1;
    enq(56'h2_1000, mkLine(64'h2100));
    enq(56'h2_2000, mkLine(64'h2200));
    ifc.BusHold = 1'b0;
    n = 0;
    while (!(ifc.BusValid === 1'b1 && ifc.BusLast === 1'b1) && n < 64) begin tick(); n++; end
    nChecks++; if (n >= 64) $display("FAIL b2b_two_wait got=timeout exp=last beat"); else nPass++;
    ifc.EnqValid = 1'b1; ifc.EnqAdr = 56'h2_3000; ifc.EnqLine = mkLine(64'h2300);
    #1;
    nChecks++; if (ifc.EnqReady !== 1'b1) $display("FAIL b2b_two_ready got=%b exp=1", ifc.EnqReady); else nPass++;
    tick();
    ifc.EnqValid = 1'b0;
    nChecks++; if (ifc.Count !== 3'd2) $display("FAIL b2b_two_count got=%0d exp=2", ifc.Count); else nPass++;
    collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || gotAdr !== 56'h2_2000) $display("FAIL b2b_two_second adr=%h exp=22000", gotAdr); else nPass++;
    collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || gotAdr !== 56'h2_3000 || gotLine !== mkLine(64'h2300)) $display("FAIL b2b_two_tail adr=%h line0=%h exp=23000/2300", gotAdr, gotLine[63:0]); else nPass++;
  endtask

  task automatic test_reset_mid();
    logic [PA_BITS-1:0] gotAdr;
    logic [LINELEN-1:0] gotLine;
    int nb, wc, se, n, seen;
    bit ok;
    doReset();
    enq(56'h7000, mkLine(64'h7000));
    n = 0;
    while (!(ifc.BusValid === 1'b1 && ifc.BusBeat === 3'd3) && n < 64) begin tick(); n++; end
    nChecks++; if (n >= 64) $display("FAIL rstmid_wait got=timeout exp=beat 3"); else nPass++;
    reset_n = 1'b0;
    #1;
    nChecks++; if (ifc.BusValid !== 1'b0 || ifc.Count !== 3'd0 || ifc.Empty !== 1'b1) $display("FAIL rstmid_async valid=%b count=%0d empty=%b exp=0/0/1", ifc.BusValid, ifc.Count, ifc.Empty); else nPass++;
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (ifc.BusValid === 1'b1) seen++; end
    nChecks++; if (seen != 0) $display("FAIL rstmid_quiet busvalid_cycles=%0d exp=0", seen); else nPass++;
    enq(56'h7100, mkLine(64'h7100));
    collectBurst(1'b0, gotAdr, gotLine, nb, wc, se, ok);
    nChecks++; if (!ok || nb != 8 || gotAdr !== 56'h7100 || gotLine !== mkLine(64'h7100)) $display("FAIL rstmid_recover beats=%0d adr=%h exp=8/7100", nb, gotAdr); else nPass++;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
